// File: rtl/vigna_muldiv_unit.sv
// RISC-V M-extension multiply/divide unit: iterative radix-2^MUL_BITS multiply, restoring divide.
// Optional last-result cache enabled by defining VIGNA_MULDIV_CACHE_EN.
module vigna_muldiv_unit #(
  parameter int XLEN     = 32,
  parameter int MUL_BITS = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            valid,
  output logic            ready,
  input  logic [2:0]      func,
  input  logic [XLEN-1:0] op1,
  input  logic [XLEN-1:0] op2,
  input  logic            flush,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic            busy
);
  // Handshake: a request transfers on a rising edge where valid && ready && !flush;
  // the requester holds func/op1/op2 stable until then. done is a one-cycle pulse.
  localparam int CW        = $clog2(XLEN) + 1;
  localparam int MUL_ITERS = XLEN / MUL_BITS;

  typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [2:0]        func_q, func_d;
  logic              s1_q, s1_d, s2_q, s2_d;
  logic [2*XLEN-1:0] mcand_q, mcand_d;  // multiplicand, or divisor in the low half
  logic [XLEN-1:0]   mplier_q, mplier_d;  // multiplier, or dividend shifting into quotient
  logic [2*XLEN-1:0] acc_q, acc_d;  // product, or partial remainder in the low half
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [XLEN-1:0]   result_q, result_d;

  // Request decode
  logic            is_div_in, op1_signed, op2_signed, s1_in, s2_in;
  logic [XLEN-1:0] mag1, mag2, special_res;
  logic            div_zero, div_ovf;

  always_comb begin
    is_div_in  = func[2];
    op1_signed = (func == 3'b001) || (func == 3'b010) || (func == 3'b100) || (func == 3'b110);
    op2_signed = (func == 3'b001) || (func == 3'b100) || (func == 3'b110);
    s1_in      = op1_signed && op1[XLEN-1];
    s2_in      = op2_signed && op2[XLEN-1];
    mag1       = s1_in ? -op1 : op1;
    mag2       = s2_in ? -op2 : op2;
    div_zero   = is_div_in && (op2 == '0);
    div_ovf    = is_div_in && !func[0] && (op1 == {1'b1, {(XLEN-1){1'b0}}}) && (op2 == '1);
    if (div_zero) special_res = func[1] ? op1 : '1;
    else          special_res = func[1] ? '0 : op1;
  end

  // Iteration datapath
  logic [2*XLEN-1:0] partial, prod;
  logic [XLEN:0]     trial, diff;
  logic              ge;
  logic [XLEN-1:0]   quot, rmag, remv, fix_res;

  always_comb begin
    partial = '0;
    for (int i = 0; i < MUL_BITS; i++) begin
      if (mplier_q[i]) partial = partial + (mcand_q << i);
    end
    trial = {acc_q[XLEN-1:0], mplier_q[XLEN-1]};
    diff  = trial - {1'b0, mcand_q[XLEN-1:0]};
    ge    = (trial >= {1'b0, mcand_q[XLEN-1:0]});
    prod  = (s1_q ^ s2_q) ? -acc_q : acc_q;
    quot  = (s1_q ^ s2_q) ? -mplier_q : mplier_q;
    rmag  = acc_q[XLEN-1:0];
    remv  = s1_q ? -rmag : rmag;
    if (func_q[2])                fix_res = func_q[1] ? remv : quot;
    else if (func_q[1:0] == 2'b00) fix_res = prod[XLEN-1:0];
    else                          fix_res = prod[2*XLEN-1:XLEN];
  end

`ifdef VIGNA_MULDIV_CACHE_EN
  logic            cache_vld_q, cache_vld_d;
  logic [2:0]      cache_func_q, cache_func_d;
  logic [XLEN-1:0] cache_op1_q, cache_op1_d, cache_op2_q, cache_op2_d;
  logic [XLEN-1:0] cache_res_q, cache_res_d, req_op1_q, req_op1_d, req_op2_q, req_op2_d;
  logic            cache_hit;

  assign cache_hit = cache_vld_q && (func == cache_func_q) && (op1 == cache_op1_q) && (op2 == cache_op2_q);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cache_vld_q  <= 1'b0;
      cache_func_q <= '0;
      cache_op1_q  <= '0;
      cache_op2_q  <= '0;
      cache_res_q  <= '0;
      req_op1_q    <= '0;
      req_op2_q    <= '0;
    end else begin
      cache_vld_q  <= cache_vld_d;
      cache_func_q <= cache_func_d;
      cache_op1_q  <= cache_op1_d;
      cache_op2_q  <= cache_op2_d;
      cache_res_q  <= cache_res_d;
      req_op1_q    <= req_op1_d;
      req_op2_q    <= req_op2_d;
    end
  end
`endif

  always_comb begin
    state_d  = state_q;
    func_d   = func_q;
    s1_d     = s1_q;
    s2_d     = s2_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    result_d = result_q;
`ifdef VIGNA_MULDIV_CACHE_EN
    cache_vld_d  = cache_vld_q;
    cache_func_d = cache_func_q;
    cache_op1_d  = cache_op1_q;
    cache_op2_d  = cache_op2_q;
    cache_res_d  = cache_res_q;
    req_op1_d    = req_op1_q;
    req_op2_d    = req_op2_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (valid && !flush) begin
          func_d = func;
          s1_d   = s1_in;
          s2_d   = s2_in;
          cnt_d  = '0;
          acc_d  = '0;
`ifdef VIGNA_MULDIV_CACHE_EN
          req_op1_d = op1;
          req_op2_d = op2;
`endif
          if (div_zero || div_ovf) begin
            result_d = special_res;
            state_d  = S_DONE;
`ifdef VIGNA_MULDIV_CACHE_EN
          end else if (cache_hit) begin
            result_d = cache_res_q;
            state_d  = S_DONE;
`endif
          end else if (is_div_in) begin
            mcand_d  = {{XLEN{1'b0}}, mag2};
            mplier_d = mag1;
            state_d  = S_DIV;
          end else begin
            mcand_d  = {{XLEN{1'b0}}, mag1};
            mplier_d = mag2;
            state_d  = S_MUL;
          end
        end
      end
      S_MUL: begin
        if (flush) state_d = S_IDLE;
        else begin
          acc_d    = acc_q + partial;
          mcand_d  = mcand_q << MUL_BITS;
          mplier_d = mplier_q >> MUL_BITS;
          cnt_d    = cnt_q + 1'b1;
          if (cnt_q == CW'(MUL_ITERS - 1)) state_d = S_FIX;
        end
      end
      S_DIV: begin
        if (flush) state_d = S_IDLE;
        else begin
          acc_d    = {{XLEN{1'b0}}, ge ? diff[XLEN-1:0] : trial[XLEN-1:0]};
          mplier_d = {mplier_q[XLEN-2:0], ge};
          cnt_d    = cnt_q + 1'b1;
          if (cnt_q == CW'(XLEN - 1)) state_d = S_FIX;
        end
      end
      S_FIX: begin
        if (flush) state_d = S_IDLE;
        else begin
          result_d = fix_res;
          state_d  = S_DONE;
`ifdef VIGNA_MULDIV_CACHE_EN
          cache_vld_d  = 1'b1;
          cache_func_d = func_q;
          cache_op1_d  = req_op1_q;
          cache_op2_d  = req_op2_q;
          cache_res_d  = fix_res;
`endif
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      func_q   <= '0;
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      func_q   <= func_d;
      s1_q     <= s1_d;
      s2_q     <= s2_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end

  assign ready  = (state_q == S_IDLE);
  assign done   = (state_q == S_DONE);
  assign busy   = (state_q == S_MUL) || (state_q == S_DIV) || (state_q == S_FIX);
  assign result = result_q;
endmodule
